cordic_iter_engine: RTL and testbench

- Parametrised, iterative CORDIC core; successor to the fixed-shift single-stage shift-accumulate cell.
- Reuses one shift-accumulate datapath for ITERS cycles, with shift amount = iteration index.
- Supports rotation and vectoring modes, uses arithmetic shifts, and has valid/ready handshakes on input and output.
- Sits between the angle/vector source and downstream gain compensation; the atan constants come from an external combinational ROM indexed by this block.

---
 rtl/cordic_iter_engine.sv | 181 ++++++++++++++++++
 tb/tb_cordic_iter_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine
//   Iterative CORDIC core. One shift-accumulate datapath is reused for
//   ITERS cycles, with shift amount equal to the iteration index. It
//   supports rotation mode (drive z to 0) and vectoring mode (drive y to 0).
//   Results are unscaled (gain ~1.6468). The atan constants come from an
//   external combinational ROM addressed by atan_idx.
//
//   Optional build macro CORDIC_ROUND_EN: when it is defined, every shift
//   term for i >= 1 is rounded as (v + 2^(i-1)) >>> i. Cycle behaviour is
//   the same in both builds.
//
// Ports
//   clk, rst_n              rising-edge clock, async active-low reset
//   in_valid / in_ready     operand handshake
//   in_mode                 0 = rotation, 1 = vectoring
//   x_in, y_in, z_in        operands (angle unit: 2^(WIDTH-1) = pi)
//   atan_idx / atan_val     ROM address (iteration index) / atan(2^-idx)
//   out_valid / out_ready   result handshake
//   x_out, y_out, z_out     result registers
//   busy                    high while running or holding a result
module cordic_iter_engine #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITERS = 16,
    parameter int unsigned IDX_W = $clog2(ITERS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic [IDX_W-1:0] atan_idx,
    input  logic [WIDTH-1:0] atan_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_ITER = IDX_W'(ITERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic                    mode_q, mode_d;
    logic [IDX_W-1:0]        iter_q, iter_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;

    logic signed [WIDTH-1:0] x_sh, y_sh;
    logic                    dir_pos;

    // Arithmetic right shift, with optional round-half-up on the dropped bits
    function automatic logic signed [WIDTH-1:0] shr(
        input logic signed [WIDTH-1:0] v,
        input logic [IDX_W-1:0]        sh
    );
`ifdef CORDIC_ROUND_EN
        logic signed [WIDTH-1:0] bias;
        bias = (sh == '0) ? '0 : $signed(WIDTH'(1) << (sh - IDX_W'(1)));
        return (v + bias) >>> sh;
`else
        return v >>> sh;
`endif
    endfunction

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        mode_d      = mode_q;
        iter_d      = iter_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        x_sh = shr(x_q, iter_q);
        y_sh = shr(y_q, iter_q);
        // z == 0 (rotation) and y == 0 (vectoring) both count as negative direction
        dir_pos = mode_q ? y_q[WIDTH-1] : (!z_q[WIDTH-1] && (z_q != '0));

        unique case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    x_d        = $signed(x_in);
                    y_d        = $signed(y_in);
                    z_d        = $signed(z_in);
                    mode_d     = in_mode;
                    iter_d     = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // Simultaneous micro-rotation using the pre-edge x, y, z
                if (dir_pos) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - $signed(atan_val);
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + $signed(atan_val);
                end
                if (iter_q == LAST_ITER) begin
                    iter_d      = '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    iter_d = iter_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                iter_d      = '0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            mode_q      <= 1'b0;
            iter_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            mode_q      <= mode_d;
            iter_q      <= iter_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    // iter_q is cleared outside RUN, so it doubles as the ROM address
    assign atan_idx  = iter_q;
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign z_out     = z_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb_cordic_iter_engine
//   Directed bench for cordic_iter_engine (WIDTH=32, ITERS=16). It provides
//   the atan ROM and an independent iterative reference for the exact
//   results. It also applies analytic tolerance checks and checks the
//   latency, handshake, backpressure, back-to-back and reset behaviour.
module tb_cordic_iter_engine;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITERS = 16;
    localparam int unsigned IDX_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] x_in, y_in, z_in;
    logic [IDX_W-1:0] atan_idx;
    logic [WIDTH-1:0] atan_val;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] x_out, y_out, z_out;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    cordic_iter_engine #(.WIDTH(WIDTH), .ITERS(ITERS), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .atan_idx  (atan_idx),
        .atan_val  (atan_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // atan(2^-i) with 2^31 = pi
    function automatic int atan_rom(input int i);
        case (i)
            0:  return 32'h20000000;
            1:  return 32'h12E4051E;
            2:  return 32'h09FB385B;
            3:  return 32'h051111D4;
            4:  return 32'h028B0D43;
            5:  return 32'h0145D7E1;
            6:  return 32'h00A2F61E;
            7:  return 32'h00517C55;
            8:  return 32'h0028BE53;
            9:  return 32'h00145F2F;
            10: return 32'h000A2F98;
            11: return 32'h000517CC;
            12: return 32'h00028BE6;
            13: return 32'h000145F3;
            14: return 32'h0000A2FA;
            15: return 32'h0000517D;
            default: return 0;
        endcase
    endfunction

    always_comb atan_val = 32'(atan_rom(int'(atan_idx)));

    function automatic int rsh(input int v, input int i);
        int t;
        t = v;
`ifdef CORDIC_ROUND_EN
        if (i > 0) t = t + (1 <<< (i - 1));
`endif
        return t >>> i;
    endfunction

    task automatic ref_cordic(input int xi, input int yi, input int zi, input bit m,
                              output int xo, output int yo, output int zo);
        int x, y, z, nx, ny;
        bit d;
        x = xi; y = yi; z = zi;
        for (int i = 0; i < int'(ITERS); i++) begin
            d = m ? (y < 0) : (z > 0);
            if (d) begin
                nx = x - rsh(y, i); ny = y + rsh(x, i); z = z - atan_rom(i);
            end else begin
                nx = x + rsh(y, i); ny = y - rsh(x, i); z = z + atan_rom(i);
            end
            x = nx; y = ny;
        end
        xo = x; yo = y; zo = z;
    endtask

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        longint d;
        n_tests++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Issue one operation, check latency/index/result, hold the result for
    // 'hold' cycles, then consume it
    task automatic do_op(input string tag, input logic [31:0] xi, input logic [31:0] yi,
                         input logic [31:0] zi, input logic m, input int hold,
                         output int xo, output int yo, output int zo);
        int  ex, ey, ez, lat, guard;
        bit  acc, idx_ok, stable;
        ref_cordic(int'(xi), int'(yi), int'(zi), m, ex, ey, ez);
        x_in = xi; y_in = yi; z_in = zi; in_mode = m;
        in_valid = 1'b1; out_ready = 1'b0;
        acc = 1'b0; guard = 0;
        while (!acc && guard < 50) begin
            acc = in_ready;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        check({tag, " accepted"}, longint'(acc), 1, 0);
        check({tag, " run busy"}, longint'(busy), 1, 0);
        check({tag, " run in_ready"}, longint'(in_ready), 0, 0);
        idx_ok = (atan_idx == '0);
        lat = 0;
        do begin
            tick();
            lat++;
            if (!out_valid && int'(atan_idx) != lat) idx_ok = 1'b0;
        end while (!out_valid && lat < 100);
        check({tag, " atan_idx seq"}, longint'(idx_ok), 1, 0);
        check({tag, " latency"}, longint'(lat), longint'(ITERS), 0);
        check({tag, " done atan_idx"}, longint'(atan_idx), 0, 0);
        check({tag, " x_out"}, longint'($signed(x_out)), longint'(ex), 0);
        check({tag, " y_out"}, longint'($signed(y_out)), longint'(ey), 0);
        check({tag, " z_out"}, longint'($signed(z_out)), longint'(ez), 0);
        xo = int'(x_out); yo = int'(y_out); zo = int'(z_out);
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            tick();
            if (int'(x_out) != xo || int'(y_out) != yo || int'(z_out) != zo ||
                !out_valid || in_ready || !busy)
                stable = 1'b0;
        end
        check({tag, " hold stable"}, longint'(stable), 1, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " consumed out_valid"}, longint'(out_valid), 0, 0);
        check({tag, " consumed busy"}, longint'(busy), 0, 0);
        check({tag, " consumed in_ready"}, longint'(in_ready), 1, 0);
    endtask

    initial begin
        int xo, yo, zo;
        int ex[2], ey[2], ez[2];
        int acc_t[2], res_t[2], rx[2], ry[2], rz[2];
        int nacc, nres, guard;
        bit will_acc, seen;

        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;

        // Reset state
        #12;
        check("rst out_valid", longint'(out_valid), 0, 0);
        check("rst busy", longint'(busy), 0, 0);
        check("rst in_ready", longint'(in_ready), 0, 0);
        check("rst atan_idx", longint'(atan_idx), 0, 0);
        check("rst x_out", longint'(x_out), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post-rst in_ready", longint'(in_ready), 1, 0);

        // Rotation by pi/4 from K*2^30; residual angle from the ROM sequence is 10616
        do_op("rot+", 32'h26DD3B6A, 32'h0, 32'h20000000, 1'b0, 0, xo, yo, zo);
        check("rot+ x approx", longint'(xo), 64'sd759250125, 32768);
        check("rot+ y approx", longint'(yo), 64'sd759250125, 32768);
        check("rot+ z residual", longint'(zo), 10616, 0);
        $display("[TB] info: rotation x error %0d LSB", xo - 759250125);

        // Rotation by -pi/4: sign handling and arithmetic shift of negatives
        do_op("rot-", 32'h26DD3B6A, 32'h0, 32'hE0000000, 1'b0, 0, xo, yo, zo);
        check("rot- x approx", longint'(xo), 64'sd759250125, 32768);
        check("rot- y approx", longint'(yo), -64'sd759250125, 32768);
        check("rot- z residual", longint'(zo), 10616, 0);

        // Vectoring on (2^29, 2^29): angle pi/4, magnitude K*sqrt(2)*2^29
        do_op("vec", 32'h20000000, 32'h20000000, 32'h0, 1'b1, 0, xo, yo, zo);
        check("vec z approx", longint'(zo), 64'sd536870912, 131072);
        check("vec y approx", longint'(yo), 0, 65536);
        check("vec x approx", longint'(xo), 64'sd1250302932, 4096);

        // Backpressure: result held for 10 cycles
        do_op("bp", 32'h10000000, 32'hF8000000, 32'h30000000, 1'b0, 10, xo, yo, zo);

        // Back-to-back with in_valid and out_ready held high
        ref_cordic(32'h10000000, 32'h08000000, 32'h40000000, 1'b0, ex[0], ey[0], ez[0]);
        ref_cordic(32'h30000000, 32'hE0000000, 32'h0, 1'b1, ex[1], ey[1], ez[1]);
        x_in = 32'h10000000; y_in = 32'h08000000; z_in = 32'h40000000; in_mode = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        nacc = 0; nres = 0; guard = 0;
        acc_t[0] = 0; acc_t[1] = 0; res_t[0] = 0; res_t[1] = 0;
        rx[0] = 0; rx[1] = 0; ry[0] = 0; ry[1] = 0; rz[0] = 0; rz[1] = 0;
        while (nres < 2 && guard < 200) begin
            will_acc = in_ready && in_valid;
            tick();
            guard++;
            if (will_acc && nacc < 2) begin
                acc_t[nacc] = cyc;
                nacc++;
                if (nacc == 1) begin
                    x_in = 32'h30000000; y_in = 32'hE0000000; z_in = 32'h0; in_mode = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                res_t[nres] = cyc;
                rx[nres] = int'(x_out); ry[nres] = int'(y_out); rz[nres] = int'(z_out);
                nres++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b accepts", longint'(nacc), 2, 0);
        check("b2b results", longint'(nres), 2, 0);
        check("b2b interval", longint'(acc_t[1] - acc_t[0]), longint'(ITERS + 2), 0);
        check("b2b lat A", longint'(res_t[0] - acc_t[0]), longint'(ITERS), 0);
        check("b2b lat B", longint'(res_t[1] - acc_t[1]), longint'(ITERS), 0);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("b2b x%0d", k), longint'(rx[k]), longint'(ex[k]), 0);
            check($sformatf("b2b y%0d", k), longint'(ry[k]), longint'(ey[k]), 0);
            check($sformatf("b2b z%0d", k), longint'(rz[k]), longint'(ez[k]), 0);
        end
        tick();

        // Reset in the middle of RUN discards the operation
        x_in = 32'h26DD3B6A; y_in = 32'h0; z_in = 32'h20000000; in_mode = 1'b0;
        in_valid = 1'b1;
        guard = 0;
        do begin
            will_acc = in_ready;
            tick();
            guard++;
        end while (!will_acc && guard < 50);
        in_valid = 1'b0;
        repeat (5) tick();
        check("midrun busy", longint'(busy), 1, 0);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", longint'(out_valid), 0, 0);
        check("midrst busy", longint'(busy), 0, 0);
        check("midrst in_ready", longint'(in_ready), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("midrst release in_ready", longint'(in_ready), 1, 0);
        seen = 1'b0;
        repeat (ITERS + 6) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        out_ready = 1'b0;
        check("midrst no result", longint'(seen), 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
